// File: rtl/ripple_fetch_unit.sv
// ripple_fetch_unit: Ripple-32i fetch stage owning the PC, issuing one word fetch at a time into a 2-entry instruction FIFO
module ripple_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] pc;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc [2];
  logic [31:0] data_n [2];
  logic [31:0] pc_n [2];
  logic [1:0] count;
  logic [2:0] level;
  logic pop, push, room, go, load, step, wr_idx;
  assign pop = inst_valid & inst_ready & ~redirect_valid;
  assign push = (state == REQ) & mem_valid & ~redirect_valid;
  assign level = {1'b0, count} - {2'b0, pop} + {2'b0, push};
  assign room = level < 3'(FIFO_DEPTH);
  assign go = ~halt & room;
  assign wr_idx = count[1] | (count[0] & ~pop);
  assign mem_en = state != IDLE;
  assign inst_valid = count != 2'd0;
  assign inst_data = fifo_data[0];
  assign inst_pc = fifo_pc[0];
  always_comb begin
    state_n = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        load = go & ~redirect_valid;
        state_n = load ? REQ : IDLE;
      end
      REQ: begin
        step = push & go;
        state_n = redirect_valid ? (mem_valid ? IDLE : FLUSH) : (mem_valid ? (go ? REQ : IDLE) : REQ);
      end
      FLUSH: state_n = mem_valid ? IDLE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    data_n = fifo_data;
    pc_n = fifo_pc;
    if (pop) begin
      data_n[0] = fifo_data[1];
      pc_n[0] = fifo_pc[1];
    end
    if (push) begin
      data_n[wr_idx] = mem_rdata;
      pc_n[wr_idx] = mem_addr;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : (push ? mem_addr + 32'd4 : pc);
      mem_addr <= load ? pc : (step ? mem_addr + 32'd4 : mem_addr);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data <= '{default: '0};
      fifo_pc <= '{default: '0};
      count <= 2'd0;
    end else begin
      fifo_data <= data_n;
      fifo_pc <= pc_n;
      count <= redirect_valid ? 2'd0 : level[1:0];
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
endmodule
